id_scoreboard: RTL
==================

# id_scoreboard

Issue controller for the decode stage. Sits between instruction decode and execute, tracks which architectural registers have a write in flight, and stalls a decoded instruction until its source and destination registers are free. It also bounds the number of outstanding writes and counts stall cycles for performance monitoring.

## Interface
- MAX_OUT, default 4: maximum outstanding register writes, range 1..31.
- CNT_W, default 16: width of the stall-cycle counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction this cycle.
- opcode  in  7  instr[6:0] of the decoded instruction.
- rs1, rs2, rd  in  5 each  register fields instr[19:15], [24:20], [11:7].
- wb_valid  in  1  a register write completes this cycle.
- wb_rd  in  5  destination register of that write.
- flush  in  1  squash all in-flight writes (pipeline redirect).
- issue  out  1  the decoded instruction is accepted this cycle.
- stall  out  1  id_valid & ~issue.
- busy  out  32  busy bit per register; bit 0 is always 0.
- out_cnt  out  $clog2(MAX_OUT+1)  current number of outstanding writes.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- wb_err  out  1  sticky flag, set by a writeback to a register that is not busy.

## Operation
- Register use is decoded from opcode:
  - 0110011 (R): rs1, rs2, rd.
  - 0010011 (I-ALU), 0000011 (load), 1100111 (JALR): rs1, rd.
  - 0100011 (store), 1100011 (branch): rs1, rs2.
  - 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL): rd.
  - Any other opcode: uses nothing and issues whenever id_valid is high.
- A used field equal to x0 is never a hazard, and x0 is never marked busy.
- Effective busy: eff = busy & ~clr. clr is the one-hot of wb_rd when wb_valid and busy[wb_rd] are both high; otherwise clr is 0. A same-cycle writeback therefore resolves the hazard.
- The hazard condition is any of:
  - a used rs1 or rs2 with eff set (RAW);
  - a used rd with eff set (WAW);
  - the instruction writes rd≠0 and (out_cnt − (clr≠0)) == MAX_OUT.
- issue = id_valid & ~hazard & ~flush.
- Next-state update, with set wins over clear for the same register:
  - busy_next = (busy & ~clr) | set, where set is the one-hot of rd when issue is high, rd is used and rd≠0.
  - out_cnt_next = out_cnt + (set≠0) − (clr≠0).
- A writeback with wb_valid high and the register not busy (this includes wb_rd=0) is ignored for busy and out_cnt. It sets wb_err.
- flush has priority over everything except rst:
  - next busy = 0 and next out_cnt = 0;
  - issue = 0 and the writeback is ignored that cycle;
  - wb_err and stall_cnt are unchanged.
- stall_cnt increments on every cycle in which stall is high, including flush cycles with id_valid high. It saturates at all-ones.

## Timing
- issue, stall and the hazard check are combinational from the inputs and current state, so decode sees zero-cycle issue latency.
- busy, out_cnt, stall_cnt and wb_err are registered.
- A register set by an issue in cycle N is visible in busy at N+1. A dependent instruction presented at N+1 stalls.
- A writeback in cycle N lets a dependent instruction issue in cycle N itself.
- rst (synchronous): busy=0, out_cnt=0, stall_cnt=0, wb_err=0 at the next edge. Combinational outputs follow the inputs with this cleared state.
- rst asserted mid-operation discards all in-flight tracking. Later writebacks to those registers then set wb_err.
- Decode must hold its instruction stable while stall is high. The block keeps no copy of the instruction.

## Test plan
- Reset, then an R-type instruction with rs1=1, rs2=2, rd=3 on an idle scoreboard -> issue=1 the same cycle; busy=0x00000008 and out_cnt=1 next cycle.
- addi rd=5 issues at N, then add with rs1=5 presented at N+1 -> stall=1 until wb_valid with wb_rd=5. The add issues in that writeback cycle; stall_cnt equals the number of stalled cycles.
- With MAX_OUT=4, issue four loads to x1..x4, then present a load to x6 -> stalled. A same-cycle writeback to x1 lets it issue, and out_cnt stays at 4.
- A store with rs1=0, rs2=0 while x1..x4 are busy -> issues immediately with no change to busy. A JAL with rd=0 issues and leaves out_cnt unchanged.
- wb_valid with wb_rd=9 while x9 is idle -> wb_err=1 next cycle and stays 1; busy and out_cnt are unchanged; rst clears wb_err.
- With x7 busy, flush together with id_valid for an instruction using x7 and wb_valid to x7 -> issue=0; next cycle busy=0, out_cnt=0, wb_err=0. An instruction presented the following cycle issues.

Source files
------------

// File: rtl/id_scoreboard.sv
// Decode-stage issue scoreboard: tracks in-flight register writes,
// stalls on RAW/WAW hazards or a full write window, counts stalls.
module id_scoreboard #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [4:0]                   rd,
    input  logic                         wb_valid,
    input  logic [4:0]                   wb_rd,
    input  logic                         flush,
    output logic                         issue,
    output logic                         stall,
    output logic [31:0]                  busy,
    output logic [$clog2(MAX_OUT+1)-1:0] out_cnt,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic                         wb_err
);

    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]      busy_q, busy_d;
    logic [OW-1:0]    out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             wb_err_q, wb_err_d;

    logic        use_rs1, use_rs2, use_rd;
    logic        clr_any, set_any, hazard;
    logic [31:0] clr, set, eff;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        unique case (opcode)
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                use_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // busy_q[0] is never set, so a writeback to x0 never clears anything
    always_comb begin
        clr_any = wb_valid & busy_q[wb_rd];
        clr     = '0;
        if (clr_any) clr[wb_rd] = 1'b1;
        eff = busy_q & ~clr;
    end

    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && rs1 != 5'd0 && eff[rs1]) hazard = 1'b1;
        if (use_rs2 && rs2 != 5'd0 && eff[rs2]) hazard = 1'b1;
        if (use_rd && rd != 5'd0) begin
            if (eff[rd]) hazard = 1'b1;
            if ((out_cnt_q - OW'(clr_any)) == OW'(MAX_OUT)) hazard = 1'b1;
        end
        issue   = id_valid & ~hazard & ~flush;
        stall   = id_valid & ~issue;
        set_any = issue & use_rd & (rd != 5'd0);
        set     = '0;
        if (set_any) set[rd] = 1'b1;
    end

    always_comb begin
        busy_d      = (busy_q & ~clr) | set;
        out_cnt_d   = out_cnt_q + OW'(set_any) - OW'(clr_any);
        wb_err_d    = wb_err_q | (wb_valid & ~busy_q[wb_rd]);
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush) begin
            busy_d    = '0;
            out_cnt_d = '0;
            wb_err_d  = wb_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            out_cnt_q   <= '0;
            stall_cnt_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_cnt_q   <= out_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign busy      = busy_q;
    assign out_cnt   = out_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign wb_err    = wb_err_q;

endmodule
